// File: rtl/bios_boot_loader.sv
// BIOS boot loader: copies ROM words into instruction memory until the halt
// word is copied, or raises error once the ROM depth is exhausted.
module bios_boot_loader #(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int          MAX_WORDS   = 101,
    parameter logic [5:0]  HALT_OPCODE = 6'b101110
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] index;
    logic              halt_seen;

    // State register; reset aborts any copy in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: three cycles per word, no overlap between words.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_WRITE;
            S_WRITE: begin
                if (halt_seen) begin
                    state_nxt = S_DONE;
                end else if (index == LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state so reset drops them immediately.
    always_comb begin
        busy   = (state == S_FETCH) || (state == S_WAIT) || (state == S_WRITE);
        done   = (state == S_DONE);
        mem_we = (state == S_WRITE);
    end

    // Datapath: address/data registers hold their values while idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base_q      <= '0;
            index       <= '0;
            rom_address <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            word_count  <= '0;
            error       <= 1'b0;
            halt_seen   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= base;
                        index       <= '0;
                        rom_address <= '0;
                        word_count  <= '0;
                        error       <= 1'b0;
                    end
                end
                S_WAIT: begin
                    mem_data    <= rom_data;
                    mem_address <= base_q + index;
                    halt_seen   <= (rom_data[DATA_W-1 -: 6] == HALT_OPCODE);
                end
                S_WRITE: begin
                    word_count <= word_count + ADDR_W'(1);
                    if (!halt_seen) begin
                        if (index == LAST) begin
                            error <= 1'b1;
                        end else begin
                            index       <= index + ADDR_W'(1);
                            rom_address <= index + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bios_boot_loader.sv
// Scoreboard bench for bios_boot_loader: stimulus queues expected writes and
// completion events, a negedge monitor pops and compares them.
module tb_bios_boot_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] base;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] word_count;

    bios_boot_loader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base        (base),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .word_count  (word_count)
    );

    // kind: 0 = write, 1 = done pulse, 2 = error rise
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        int          wc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rom [128];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_err = 1'b0;
    int          t0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered ROM read port
    always @(posedge clock) begin
        if (rom_address < 32'd101) rom_data <= rom[rom_address[6:0]];
        else rom_data <= 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset) begin
            if (mem_we) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %h data %h", mem_address, mem_data);
                end else begin
                    e = q.pop_front();
                    chk("write_kind", 32'(0), 32'(e.kind));
                    chk("write_addr", mem_address, e.addr);
                    chk("write_data", mem_data, e.data);
                    chk("write_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    e = q.pop_front();
                    chk("done_kind", 32'(1), 32'(e.kind));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_word_count", word_count, 32'(e.wc));
                    chk("done_error", 32'(error), 32'(0));
                    chk("done_busy", 32'(busy), 32'(0));
                end
            end
            if (error && !prev_err) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_error: got 1 expected 0");
                end else begin
                    e = q.pop_front();
                    chk("error_kind", 32'(2), 32'(e.kind));
                    chk("error_cycle", 32'(cyc), 32'(e.cyc));
                    chk("error_word_count", word_count, 32'(e.wc));
                    chk("error_busy", 32'(busy), 32'(0));
                end
            end
        end
        prev_err = error;
    end

    // Fill ROM with non-halt words; place the halt word at halt_at (if >= 0)
    task automatic load_prog(input int halt_at);
        for (int i = 0; i < 128; i++)
            rom[i] = {6'(1 + i % 5), 26'(i * 1234567 + 99)};
        if (halt_at >= 0) rom[halt_at] = {6'b101110, 26'(halt_at)};
    endtask

    // end_cycle is in cycle numbering (cycle 1 = first after start edge)
    task automatic run_copy(input logic [31:0] b, input int nw,
                            input int kind_end, input int end_cycle,
                            output int t);
        @(negedge clock);
        base  = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        t = cyc;
        for (int i = 0; i < nw; i++)
            q.push_back('{0, b + 32'(i), rom[i], t + 3 * i + 2, 0});
        if (kind_end >= 0)
            q.push_back('{kind_end, 32'h0, 32'h0, t + end_cycle - 1, nw});
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(posedge clock);
            k++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, q.size());
            q.delete();
        end
        repeat (4) @(posedge clock);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        base  = 32'h0;
        load_prog(58);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_we", 32'(mem_we), 32'(0));
        chk("rst_wc", word_count, 32'h0);
        chk("rst_rom_addr", rom_address, 32'h0);
        chk("rst_mem_addr", mem_address, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // 59-word program, done in cycle 178
        load_prog(58);
        run_copy(32'h0, 59, 1, 178, t0);
        drain("prog59", 400);

        // halt at index 0, base 0x100, done in cycle 4
        load_prog(0);
        chk("halt_word_value", rom[0], 32'hB800_0000);
        run_copy(32'h100, 1, 1, 4, t0);
        drain("halt0", 50);

        // no halt word: 101 writes, error in cycle 304
        load_prog(-1);
        run_copy(32'h0, 101, 2, 304, t0);
        drain("nohalt", 600);
        chk("nohalt_error_level", 32'(error), 32'(1));

        // address wrap, done in cycle 13
        load_prog(3);
        run_copy(32'hFFFF_FFFE, 4, 1, 13, t0);
        drain("wrap", 100);

        // reset in cycle 5 (WAIT of word 1): only word 0 written
        load_prog(58);
        run_copy(32'h0, 1, -1, 0, t0);
        while (cyc != t0 + 4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_we", 32'(mem_we), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_pending", 32'(q.size()), 32'(0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        load_prog(3);
        run_copy(32'h40, 4, 1, 13, t0);
        drain("after_rst", 100);

        // error set first, then a new start clears it; extra start ignored
        load_prog(-1);
        run_copy(32'h0, 101, 2, 304, t0);
        drain("nohalt2", 600);
        load_prog(3);
        run_copy(32'h0, 4, 1, 13, t0);
        chk("restart_error_clr", 32'(error), 32'(0));
        chk("restart_wc_clr", word_count, 32'h0);
        while (cyc != t0 + 6) @(posedge clock);
        #1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        drain("busy_start", 100);
        chk("final_wc", word_count, 32'd4);

        // restart after done clears word_count
        run_copy(32'h200, 4, 1, 13, t0);
        chk("restart2_wc_clr", word_count, 32'h0);
        drain("restart2", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bios_boot_loader.md
# bios_boot_loader

Boot-time copy engine that reads the BIOS ROM word by word and writes each word into instruction/OS memory. It is the read-side initiator for the BIOS ROM's registered read port. It stops after copying the halt word (opcode 101110), or flags an error when the ROM depth is exhausted. It sits between the BIOS ROM and the memory write port and runs before the processor is released from boot.

## Interface
- ADDR_W, 32, width of ROM and memory addresses
- DATA_W, 32, word width
- MAX_WORDS, 101, ROM depth; indices 0..MAX_WORDS-1
- HALT_OPCODE, 6'b101110, value of data[31:26] that terminates the copy

- clock  in  1  system clock, rising edge; also drives the ROM read register
- reset  in  1  asynchronous, active-low
- start  in  1  begin a copy; sampled only in IDLE
- base  in  ADDR_W  destination base address; latched when start is accepted
- rom_address  out  ADDR_W  registered ROM read address
- rom_data  in  DATA_W  ROM output; registered by the ROM one clock after rom_address
- mem_address  out  ADDR_W  write address, base + index
- mem_data  out  DATA_W  write data
- mem_we  out  1  write strobe, one cycle per word
- busy  out  1  high in FETCH, WAIT and WRITE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  level; set when no halt word is found in MAX_WORDS words
- word_count  out  ADDR_W  words written in the current or last copy, including the halt word

## Operation
- States: IDLE, FETCH, WAIT, WRITE, DONE. Each word takes 3 cycles with no pipelining.
- IDLE, start=1:
  - latch base; index←0; rom_address←0; word_count←0; error←0
  - go to FETCH
- FETCH: rom_address is stable. The ROM captures it at the end of this cycle. Go to WAIT.
- WAIT: rom_data is valid. At the end of the cycle:
  - mem_data←rom_data; mem_address←base+index; mem_we←1
  - halt_seen←(rom_data[31:26]==HALT_OPCODE)
  - go to WRITE
- WRITE: mem_we=1 for exactly this cycle. At the end of the cycle, mem_we←0 and word_count←word_count+1, then:
  - if halt_seen, go to DONE
  - else if index==MAX_WORDS-1, set error←1 and go to IDLE
  - else index←index+1; rom_address←index+1; go to FETCH
- DONE: done=1 for one cycle, then go to IDLE.
- The halt word is itself copied, so downstream memory holds a terminated program.
- base+index wraps modulo 2^ADDR_W. No overflow flag is raised.
- start while busy or in DONE is ignored. It is not queued.
- start in IDLE in the same cycle error is being cleared: the new copy starts and error reads 0.
- mem_data, mem_address and rom_address hold their last values in IDLE. Only mem_we qualifies a write.

## Timing
- Reset (asynchronous, immediate): state=IDLE; all outputs 0, including mem_we, busy, done, error, word_count, rom_address, mem_address and mem_data.
- Reset mid-copy: the copy aborts, mem_we drops without waiting for a clock edge, and no further writes occur. Partially written memory is left as is.
- Cycle numbering: cycle 1 is the first cycle after the edge that samples start=1.
- Word i:
  - FETCH in cycle 3i+1
  - WAIT in cycle 3i+2
  - mem_we high in cycle 3i+3
- N words ending in halt: done is high in cycle 3N+1, and busy falls in the same cycle.
- Start-to-done latency is 3N+1 cycles.
- Halt never found: the last write is in cycle 3·MAX_WORDS, and error rises in cycle 3·MAX_WORDS+1 with no done pulse.
- The earliest restart is start sampled in the done cycle's following IDLE cycle.

## Test plan
- ROM preloaded with a 59-word program (halt at index 58), base=0, start pulse:
  - 59 writes at addresses 0..58 with data identical to the ROM
  - done high in cycle 178; word_count=59; error=0
- Halt at index 0, base=0x100:
  - exactly one write, to address 0x100 with data 0xB8000000
  - done in cycle 4; word_count=1
- ROM with no halt word, MAX_WORDS=101:
  - 101 writes
  - error=1 in cycle 304; no done pulse; word_count=101
- base=0xFFFFFFFE, halt at index 3:
  - writes to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1
  - done in cycle 13
- reset asserted in cycle 5 (WAIT of word 1):
  - mem_we and busy go low immediately
  - only the word-0 write has occurred
  - after release, a new start copies from index 0
- start pulsed again in cycle 7 during a copy:
  - no effect; the copy completes with unchanged timing
  - a start after DONE restarts the copy and clears word_count and error
